// File: rtl/color_step_driver.sv
`default_nettype none
// ============================================================================
// Module   : color_step_driver
// Function : Emits clean step pulses that walk a color mixer from its shadowed
//            current state to a requested target index (wrap modulo 8).
// Revision : 1.0
// ============================================================================
module color_step_driver #(
    parameter int PULSE_HIGH_CYCLES = 4,
    parameter int PULSE_LOW_CYCLES  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start_i,
    input  logic [2:0] target_i,
    output logic       step_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] pos_o,
    output logic [2:0] color_o
);

    localparam int MAX_PULSE = (PULSE_HIGH_CYCLES > PULSE_LOW_CYCLES) ?
                               PULSE_HIGH_CYCLES : PULSE_LOW_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PULSE) + 1;

    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(PULSE_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(PULSE_LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       remaining;
    logic [2:0]       diff;
    logic [2:0]       rem_base;
    logic             enter_high;

    // Distance to target wraps naturally in 3-bit arithmetic.
    assign diff     = target_i - pos_o;
    assign rem_base = (state == ST_IDLE) ? diff : remaining;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    next_state = (diff == 3'd0) ? ST_DONE : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt == HIGH_LAST) begin
                    next_state = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt == LOW_LAST) begin
                    next_state = (remaining != 3'd0) ? ST_HIGH : ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        enter_high = (next_state == ST_HIGH) && (state != ST_HIGH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            remaining <= 3'd0;
            pos_o     <= 3'd0;
            step_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state != state) || (state == ST_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // The shadow position advances on the edge that raises step_o.
            if (enter_high) begin
                pos_o     <= pos_o + 3'd1;
                remaining <= rem_base - 3'd1;
            end else if ((state == ST_IDLE) && start_i) begin
                remaining <= diff;
            end

            step_o <= (next_state == ST_HIGH);
            busy_o <= (next_state != ST_IDLE);
            done_o <= (next_state == ST_DONE);
        end
    end

    always_comb begin
        color_o = 3'b000;
        case (pos_o)
            3'd0: color_o = 3'b000;
            3'd1: color_o = 3'b100;
            3'd2: color_o = 3'b010;
            3'd3: color_o = 3'b001;
            3'd4: color_o = 3'b110;
            3'd5: color_o = 3'b011;
            3'd6: color_o = 3'b101;
            3'd7: color_o = 3'b111;
            default: color_o = 3'b000;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/color_step_driver.md
Name: color_step_driver

Overview:
- Initiator counterpart to the color mixer's button input. It generates clean step pulses on a single line, each equivalent to one debounced SW2 press.
- It keeps a shadow copy of the mixer's 3-bit color state. Given a target color index, it emits exactly the number of pulses needed to advance the mixer from its current state to the target, with wrap modulo 8.
- Used for self-test and automated demo sequencing; step_o drives the mixer's step input in place of the debounced switch.

Parameters:
- PULSE_HIGH_CYCLES, 4, clock cycles step_o is held high per pulse (>=1)
- PULSE_LOW_CYCLES, 4, clock cycles step_o is held low after each pulse (>=1)

Ports:
- CLK  input  1  system clock; all logic on the rising edge
- RST  input  1  synchronous, active-high reset
- start_i  input  1  request a move; accepted only in IDLE
- target_i  input  3  target color index 0..7; sampled only on an accepted start
- step_o  output  1  step pulse train to the mixer; active high
- busy_o  output  1  high while a request is in progress (HIGH/LOW/DONE states)
- done_o  output  1  one-cycle pulse when a request completes
- pos_o  output  3  shadow mixer state
- color_o  output  3  active-high {R,G,B} decode of pos_o

Behaviour:
- Reset (synchronous, RST high at an edge): state=IDLE, step_o=0, busy_o=0, done_o=0, pos_o=0, color_o=000. Counters cleared. Reset has priority over every other input, including mid-pulse: step_o drops to 0 on that same edge.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - If start_i=1 at edge N: latch remaining = (target_i - pos_o) mod 8, computed with 3-bit wrapping subtraction.
  - If remaining=0, go to DONE at N+1 with no pulses.
  - Otherwise go to HIGH at N+1.
  - start_i is ignored in every state other than IDLE; target_i is not re-sampled.
- HIGH:
  - step_o=1 for exactly PULSE_HIGH_CYCLES cycles.
  - On entry to HIGH (the cycle step_o rises), pos_o increments by 1, wrapping 7->0, and remaining decrements.
  - Then go to LOW.
- LOW:
  - step_o=0 for exactly PULSE_LOW_CYCLES cycles.
  - Then go to HIGH if remaining!=0, else DONE.
- DONE:
  - done_o=1 and busy_o=1 for exactly one cycle, then IDLE.
  - A start_i asserted during DONE is ignored.
- busy_o=1 in HIGH, LOW and DONE.
- Latency:
  - For k pulses: busy_o spans k*(PULSE_HIGH_CYCLES+PULSE_LOW_CYCLES)+1 cycles.
  - The first step_o rise is at N+1.
  - done_o is high at N+1+k*(H+L).
  - For k=0, done_o is high at N+1.
- color_o is a combinational decode of pos_o: 0->000, 1->100 (R), 2->010 (G), 3->001 (B), 4->110 (Y), 5->011 (C), 6->101 (M), 7->111 (W).
- Width rules:
  - Pulse counters are sized with $clog2 of the larger parameter plus 1.
  - remaining is 3 bits, maximum 7 pulses per request.
- The shadow pos_o assumes the mixer started from IDLE together with RST and sees no other step source. No resync input is provided.

Test Plan:
- Reset then idle: hold RST 2 cycles, release -> step_o=0, busy_o=0, done_o=0, pos_o=0, color_o=000 held while start_i=0.
- Basic move (H=L=4): from pos 0, start_i with target_i=3 at cycle N:
  - 3 pulses, step_o high N+1..N+4, N+9..N+12, N+17..N+20.
  - pos_o reads 1, 2, 3 at the rising edges.
  - done_o high only at N+25.
  - color_o=001 afterwards.
- Wrap-around: from pos 3, target_i=1:
  - 6 pulses; pos_o sequence 4, 5, 6, 7, 0, 1.
  - color_o ends 100.
  - busy_o high 49 cycles.
- Zero move: target_i equals pos_o (e.g. 5) -> no step_o activity, done_o high at N+1, busy_o high one cycle, pos_o unchanged.
- Start while busy: during a 3-step move, pulse start_i with target_i=7 in HIGH, LOW and DONE -> all ignored; move ends at pos 3; a new start issued in IDLE afterwards is honoured (4 pulses to 7).
- Reset mid-pulse and minimum timing:
  - RST during the 2nd HIGH of a move -> next edge step_o=0, busy_o=0, pos_o=0, no done_o.
  - With H=L=1, target 2 -> step_o pattern 1,0,1,0, then done_o, total busy 5 cycles.
